// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32I pipeline hazard controller.
// The macro HAZARD_PERF_CNT_EN is consumed by hazard_ctrl_unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    MEMERR  = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // M-stage result is younger than W, so it wins.
  function automatic fwd_sel_e fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       we_m,
    input logic       we_w
  );
    if (we_m && rd_m != REG_X0 && rd_m == rs)
      return FWD_M;
    else if (we_w && rd_w != REG_X0 && rd_w == rs)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Enable-driven event counter that sticks at all-ones.
// Used for hazard performance statistics.
module hazard_sat_counter
  import hazard_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_en && r_cnt != '1)
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward control for the 5-stage RV32I pipeline with a data-memory wait FSM.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_fwd
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(TIMEOUT - 1);

  hz_state_e      r_state;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_mem_timeout;

  logic w_lw_stall;
  logic w_frozen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          r_wait_cnt <= '0;
          if (MemReqM && !MemReadyM)
            r_state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (MemReadyM) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_LAST) begin
            r_state       <= MEMERR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        MEMERR: begin
          if (MemReadyM) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout;

  assign w_lw_stall = ResultSrcE0 && (RdE != REG_X0)
                   && ((Rs1D == RdE) || (Rs2D == RdE));

  // The cycle ready arrives already behaves like RUN.
  assign w_frozen = (r_state != RUN) && !MemReadyM;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
      if (w_frozen) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = w_lw_stall;
        StallD = w_lw_stall;
        FlushE = w_lw_stall | PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_flush_any;
  logic w_fwd_any;

  assign w_flush_any = FlushD | FlushE;
  assign w_fwd_any   = (ForwardAE != FWD_RF) || (ForwardBE != FWD_RF);

  hazard_sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .reset (reset),
    .i_en  (StallD),
    .o_cnt (cnt_stall)
  );

  hazard_sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_flush_any),
    .o_cnt (cnt_flush)
  );

  hazard_sat_counter #(.W(CNT_W)) u_cnt_fwd (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_fwd_any),
    .o_cnt (cnt_fwd)
  );
`else
  assign cnt_stall = '0;
  assign cnt_flush = '0;
  assign cnt_fwd   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: vector table, memory-wait/timeout sequences,
// mid-wait reset and counter saturation, checked through an expectation queue.
module tb_hazard_ctrl_unit;

  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       lde, rwm, rww, pc, req, rdy;
  } in_t;

  typedef struct packed {
    logic       sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  in_t  cur;
  out_t act;

  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_timeout;
  logic [CW-1:0] cnt_stall, cnt_flush, cnt_fwd;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1D        (cur.rs1d),
    .Rs2D        (cur.rs2d),
    .Rs1E        (cur.rs1e),
    .Rs2E        (cur.rs2e),
    .RdE         (cur.rde),
    .RdM         (cur.rdm),
    .RdW         (cur.rdw),
    .ResultSrcE0 (cur.lde),
    .RegWriteM   (cur.rwm),
    .RegWriteW   (cur.rww),
    .PCSrcE      (cur.pc),
    .MemReqM     (cur.req),
    .MemReadyM   (cur.rdy),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .mem_timeout (mem_timeout),
    .cnt_stall   (cnt_stall),
    .cnt_flush   (cnt_flush),
    .cnt_fwd     (cnt_fwd)
  );

  assign act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE};

  int   pass_n = 0;
  int   tot_n  = 0;
  int   ms     = 0;
  int   mcnt   = 0;
  bit   mto    = 1'b0;
  int   cs     = 0;
  int   cf     = 0;
  int   cw     = 0;
  int   se_cycles = 0;
  out_t q[$];
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    tot_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] rs, input in_t v);
    if (v.rwm && v.rdm != 5'd0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 5'd0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t mcomb(input in_t v);
    out_t o;
    bit   lw;
    o = '0;
    o.fa = mfwd(v.rs1e, v);
    o.fb = mfwd(v.rs2e, v);
    lw = v.lde && v.rde != 5'd0 && (v.rs1d == v.rde || v.rs2d == v.rde);
    if (ms != 0 && !v.rdy) begin
      o.sf = 1; o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1;
    end else begin
      o.sf = lw; o.sd = lw; o.fe = lw | v.pc; o.fd = v.pc;
    end
    return o;
  endfunction

  task automatic model_clock(input in_t v, input out_t o);
    if (PERF) begin
      if (o.sd && cs < CMAX) cs++;
      if ((o.fd || o.fe) && cf < CMAX) cf++;
      if ((o.fa != 0 || o.fb != 0) && cw < CMAX) cw++;
    end
    case (ms)
      0: begin mcnt = 0; if (v.req && !v.rdy) ms = 1; end
      1: begin
        if (v.rdy) begin ms = 0; mcnt = 0; end
        else if (mcnt == TO - 1) begin ms = 2; mto = 1; end
        else mcnt++;
      end
      default: if (v.rdy) begin ms = 0; mcnt = 0; end
    endcase
  endtask

  task automatic model_reset();
    ms = 0; mcnt = 0; mto = 0; cs = 0; cf = 0; cw = 0;
  endtask

  task automatic step(input in_t v, input bit hand, input out_t e, input string nm);
    out_t x;
    @(negedge clk);
    cur = v;
    q.push_back(hand ? e : mcomb(v));
    #1;
    x = q.pop_front();
    check(nm, 32'(act), 32'(x));
    if (act.se === 1'b1) se_cycles++;
    model_clock(v, x);
    @(posedge clk);
    #1;
    check({nm, "/cnt"}, {23'd0, cnt_stall, cnt_flush, cnt_fwd},
          {23'd0, cs[CW-1:0], cf[CW-1:0], cw[CW-1:0]});
    check({nm, "/to"}, 32'(mem_timeout), 32'(mto));
  endtask

  in_t  w;
  out_t z;

  initial begin
    z = '0;
    reset = 1'b1;
    cur = in_t'{rs1e: 5'd5, rdm: 5'd5, rwm: 1'b1, lde: 1'b1, rde: 5'd2,
                rs1d: 5'd2, pc: 1'b1, default: '0};
    @(posedge clk);
    #1;
    check("rst_outputs", 32'(act), 32'd0);
    check("rst_counters", {23'd0, cnt_stall, cnt_flush, cnt_fwd}, 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cur = '0;

    tbl.push_back('{in_t'{rs1e: 5, rdm: 5, rwm: 1, rdw: 5, rww: 1, default: 0},
                    out_t'{fa: 2'b10, default: 0}, "fwd_m_wins"});
    tbl.push_back('{in_t'{rs1e: 5, rdm: 0, rwm: 1, rdw: 5, rww: 1, default: 0},
                    out_t'{fa: 2'b01, default: 0}, "fwd_w_rdm0"});
    tbl.push_back('{in_t'{rs2e: 9, rdm: 3, rwm: 1, rdw: 9, rww: 1, default: 0},
                    out_t'{fb: 2'b01, default: 0}, "fwd_b_w"});
    tbl.push_back('{in_t'{rs1e: 0, rs2e: 0, rdm: 0, rwm: 1, rdw: 0, rww: 1, default: 0},
                    out_t'{default: 0}, "fwd_never_x0"});
    tbl.push_back('{in_t'{rs1e: 5, rdm: 5, rwm: 0, default: 0},
                    out_t'{default: 0}, "fwd_no_we"});
    tbl.push_back('{in_t'{rs1e: 4, rs2e: 4, rdm: 4, rwm: 1, default: 0},
                    out_t'{fa: 2'b10, fb: 2'b10, default: 0}, "fwd_ab_m"});
    tbl.push_back('{in_t'{lde: 1, rde: 7, rs2d: 7, default: 0},
                    out_t'{sf: 1, sd: 1, fe: 1, default: 0}, "lw_stall"});
    tbl.push_back('{in_t'{lde: 1, rde: 0, rs1d: 0, default: 0},
                    out_t'{default: 0}, "lw_rd_x0"});
    tbl.push_back('{in_t'{lde: 1, rde: 3, rs1d: 3, pc: 1, default: 0},
                    out_t'{sf: 1, sd: 1, fd: 1, fe: 1, default: 0}, "lw_and_branch"});
    tbl.push_back('{in_t'{pc: 1, default: 0},
                    out_t'{fd: 1, fe: 1, default: 0}, "branch_only"});
    tbl.push_back('{in_t'{lde: 0, rde: 7, rs2d: 7, default: 0},
                    out_t'{default: 0}, "not_load"});
    foreach (tbl[k]) step(tbl[k].i, 1'b1, tbl[k].o, tbl[k].nm);

    // memory wait released after three frozen cycles
    se_cycles = 0;
    w = in_t'{req: 1, rdy: 0, pc: 1, lde: 1, rde: 2, rs1d: 2,
              rs1e: 6, rdm: 6, rwm: 1, default: 0};
    for (int i = 0; i < 4; i++) step(w, 1'b0, z, "memwait");
    w.rdy = 1'b1;
    step(w, 1'b0, z, "memwait_ready");
    step('0, 1'b1, z, "memwait_idle");
    check("memwait_stall_cycles", 32'(se_cycles), 32'd3);
    check("memwait_no_timeout", 32'(mem_timeout), 32'd0);

    // timeout into MEMERR
    se_cycles = 0;
    w = in_t'{req: 1, rdy: 0, default: 0};
    for (int i = 0; i < 10; i++) begin
      step(w, 1'b0, z, "timeout_wait");
      if (i == 3) check("timeout_not_yet", 32'(mem_timeout), 32'd0);
      if (i == 4) check("timeout_raised", 32'(mem_timeout), 32'd1);
    end
    check("timeout_stall_cycles", 32'(se_cycles), 32'd9);
    w.rdy = 1'b1;
    step(w, 1'b1, z, "memerr_ready");
    step('0, 1'b1, z, "after_err_idle");
    check("timeout_sticky", 32'(mem_timeout), 32'd1);

    // asynchronous reset in the middle of a wait
    w.rdy = 1'b0;
    step(w, 1'b0, z, "pre_rst_wait0");
    step(w, 1'b0, z, "pre_rst_wait1");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midwait_rst_out", 32'(act), 32'd0);
    check("midwait_rst_to", 32'(mem_timeout), 32'd0);
    check("midwait_rst_cnt", {23'd0, cnt_stall, cnt_flush, cnt_fwd}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cur = '0;
    step('0, 1'b1, z, "post_rst_run");

    // counter saturation
    w = in_t'{lde: 1, rde: 7, rs2d: 7, default: 0};
    for (int i = 0; i < 9; i++)
      step(w, 1'b1, out_t'{sf: 1, sd: 1, fe: 1, default: 0}, "sat_stall");
    check("cnt_stall_sat", 32'(cnt_stall), PERF ? 32'd7 : 32'd0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
